// File: rtl/mem_stage_pkg.sv
// Shared widths, es_rf_zip field positions and load-type indices for the MEM stage.
package mem_stage_pkg;

  localparam int unsigned DW          = 32;
  localparam int unsigned RFAW        = 5;
  localparam int unsigned ES_RF_ZIP_W = 41;
  localparam int unsigned MS2WS_W     = 72;
  localparam int unsigned MS_FWD_W    = 39;
  localparam int unsigned LD_ZIP_W    = 5;

  // es_rf_zip = {csr_zip, csr_re, res_from_mem, rf_we, rf_waddr, alu_result}
  localparam int unsigned ALU_LSB          = 0;
  localparam int unsigned WADDR_LSB        = 32;
  localparam int unsigned RF_WE_BIT        = 37;
  localparam int unsigned RES_FROM_MEM_BIT = 38;
  localparam int unsigned CSR_RE_BIT       = 39;
  localparam int unsigned CSR_ZIP_BIT      = 40;

  // es_res_from_mem_zip = {ld_b, ld_h, ld_w, ld_bu, ld_hu}
  localparam int unsigned LD_HU = 0;
  localparam int unsigned LD_BU = 1;
  localparam int unsigned LD_W  = 2;
  localparam int unsigned LD_H  = 3;
  localparam int unsigned LD_B  = 4;

endpackage

// File: rtl/mem_stage_if.sv
// EXE->MEM->WB handshake, SRAM read data and ID bypass signals of the MEM stage.
interface mem_stage_if;
  import mem_stage_pkg::*;

  logic                   ms_allowin;
  logic                   es2ms_valid;
  logic [ES_RF_ZIP_W-1:0] es_rf_zip;
  logic [DW-1:0]          es_pc;
  logic [LD_ZIP_W-1:0]    es_res_from_mem_zip;
  logic [DW-1:0]          data_sram_rdata;
  logic                   ws_allowin;
  logic                   ms2ws_valid;
  logic [MS2WS_W-1:0]     ms2ws_bus;
  logic [MS_FWD_W-1:0]    ms_fwd_zip;

  modport master (
    input  ms_allowin, ms2ws_valid, ms2ws_bus, ms_fwd_zip,
    output es2ms_valid, es_rf_zip, es_pc, es_res_from_mem_zip, data_sram_rdata, ws_allowin
  );

  modport slave (
    output ms_allowin, ms2ws_valid, ms2ws_bus, ms_fwd_zip,
    input  es2ms_valid, es_rf_zip, es_pc, es_res_from_mem_zip, data_sram_rdata, ws_allowin
  );

endinterface

// File: rtl/mem_load_align.sv
// Combinational load-data extractor: selects byte/half lane by address and extends per load type.
module mem_load_align
  import mem_stage_pkg::*;
(
  input  logic [LD_ZIP_W-1:0] ld_zip,
  input  logic [1:0]          addr,
  input  logic [DW-1:0]       rdata,
  output logic [DW-1:0]       wdata
);

  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  always_comb begin
    lane_b = rdata[{addr, 3'b000} +: 8];
    lane_h = rdata[{addr[1], 4'b0000} +: 16];
    wdata  = '0;
    if (ld_zip[LD_B]) begin
      wdata = {{24{lane_b[7]}}, lane_b};
    end else if (ld_zip[LD_BU]) begin
      wdata = {24'h0, lane_b};
    end else if (ld_zip[LD_H]) begin
      wdata = {{16{lane_h[15]}}, lane_h};
    end else if (ld_zip[LD_HU]) begin
      wdata = {16'h0, lane_h};
    end else if (ld_zip[LD_W]) begin
      wdata = rdata;
    end
  end

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: latches EXE results, extracts load data, feeds WB and the ID bypass.
// Define MEM_FWD_EN to bypass final (load-extracted) write data to ID instead of alu_result.
module mem_stage
  import mem_stage_pkg::*;
(
  input logic        clk,
  input logic        resetn,
  mem_stage_if.slave bus
);

  logic                   ms_valid_q;
  logic [ES_RF_ZIP_W-1:0] rf_zip_q;
  logic [DW-1:0]          pc_q;
  logic [LD_ZIP_W-1:0]    ld_zip_q;
  logic [DW-1:0]          rbuf_q;
  logic                   rbuf_valid_q;

  logic            ms_ready_go;
  logic            allowin;
  logic            out_valid;
  logic            latch;
  logic            leave;
  logic            capture;
  logic [DW-1:0]   alu_result;
  logic [RFAW-1:0] waddr;
  logic            rf_we;
  logic            res_from_mem;
  logic            csr_re;
  logic            csr_zip;
  logic [DW-1:0]   ld_rdata;
  logic [DW-1:0]   ld_wdata;
  logic [DW-1:0]   final_wdata;

  assign alu_result   = rf_zip_q[ALU_LSB +: DW];
  assign waddr        = rf_zip_q[WADDR_LSB +: RFAW];
  assign rf_we        = rf_zip_q[RF_WE_BIT];
  assign res_from_mem = rf_zip_q[RES_FROM_MEM_BIT];
  assign csr_re       = rf_zip_q[CSR_RE_BIT];
  assign csr_zip      = rf_zip_q[CSR_ZIP_BIT];

  assign ms_ready_go = 1'b1;
  assign allowin     = ~ms_valid_q | (ms_ready_go & bus.ws_allowin);
  assign out_valid   = ms_valid_q & ms_ready_go;
  assign latch       = bus.es2ms_valid & allowin;
  assign leave       = out_valid & bus.ws_allowin;
  // Hold the SRAM word while WB stalls; EXE may already be driving a newer read onto the port.
  assign capture     = ms_valid_q & res_from_mem & ~rbuf_valid_q & ~leave;
  assign ld_rdata    = rbuf_valid_q ? rbuf_q : bus.data_sram_rdata;

  mem_load_align u_align (
    .ld_zip (ld_zip_q),
    .addr   (alu_result[1:0]),
    .rdata  (ld_rdata),
    .wdata  (ld_wdata)
  );

  assign final_wdata = res_from_mem ? ld_wdata : alu_result;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ms_valid_q <= 1'b0;
      rf_zip_q   <= '0;
      pc_q       <= '0;
      ld_zip_q   <= '0;
    end else begin
      if (allowin) begin
        ms_valid_q <= bus.es2ms_valid;
      end
      if (latch) begin
        rf_zip_q <= bus.es_rf_zip;
        pc_q     <= bus.es_pc;
        ld_zip_q <= bus.es_res_from_mem_zip;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rbuf_valid_q <= 1'b0;
      rbuf_q       <= '0;
    end else if (leave || latch) begin
      rbuf_valid_q <= 1'b0;
    end else if (capture) begin
      rbuf_valid_q <= 1'b1;
      rbuf_q       <= bus.data_sram_rdata;
    end
  end

  assign bus.ms_allowin  = allowin;
  assign bus.ms2ws_valid = out_valid;
  assign bus.ms2ws_bus   = {csr_zip, csr_re & ms_valid_q, rf_we & ms_valid_q, waddr, final_wdata,
                            pc_q};

`ifdef MEM_FWD_EN
  logic data_ready;
  // Synchronous SRAM: read data is always present during the MEM cycle.
  assign data_ready     = 1'b1;
  assign bus.ms_fwd_zip = {ms_valid_q & res_from_mem & ~data_ready, ms_valid_q & rf_we, waddr,
                           final_wdata};
`else
  assign bus.ms_fwd_zip = {ms_valid_q & res_from_mem, ms_valid_q & rf_we, waddr, alu_result};
`endif

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: directed load cases, stall/hold, reset, then random traffic.
module tb_mem_stage;
  import mem_stage_pkg::*;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  mem_stage_if bus ();

  mem_stage dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  int checks = 0;
  int errors = 0;

  logic [71:0] q_bus[$];
  logic [38:0] q_fwd[$];
  logic        mem_full = 1'b0;
  logic        load_last = 1'b0;
  logic [31:0] rdata_next = '0;

  task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [40:0] mk_zip(input logic cz, input logic cr, input logic rfm,
                                         input logic we, input logic [4:0] wa,
                                         input logic [31:0] alu);
    return {cz, cr, rfm, we, wa, alu};
  endfunction

  // Reference extraction written from the load rules with shifts and explicit extension.
  function automatic logic [31:0] ref_wdata(input logic [40:0] zip, input logic [4:0] ld,
                                            input logic [31:0] rdata);
    logic [31:0] alu;
    int          a;
    logic [7:0]  b;
    logic [15:0] h;
    alu = zip[31:0];
    a   = int'(alu[1:0]);
    b   = 8'(rdata >> (8 * a));
    h   = 16'(rdata >> (16 * (a / 2)));
    if (!zip[38]) return alu;
    if (ld[LD_B])  return {{24{b[7]}}, b};
    if (ld[LD_BU]) return {24'h0, b};
    if (ld[LD_H])  return {{16{h[15]}}, h};
    if (ld[LD_HU]) return {16'h0, h};
    if (ld[LD_W])  return rdata;
    return 32'h0;
  endfunction

  // Called at posedge+1; returns at the next posedge+1.
  task automatic drive_cycle(input logic v, input logic [40:0] zip, input logic [31:0] pc,
                             input logic [4:0] ld, input logic [31:0] plan, input logic wsa,
                             input logic [31:0] junk);
    logic        accept;
    logic        full_n;
    logic [31:0] wd;
    bus.data_sram_rdata     = load_last ? rdata_next : junk;
    bus.ws_allowin          = wsa;
    bus.es2ms_valid         = v;
    bus.es_rf_zip           = zip;
    bus.es_pc               = pc;
    bus.es_res_from_mem_zip = ld;
    #1;
    check("ms_allowin", {71'h0, bus.ms_allowin}, {71'h0, (!mem_full || wsa)});
    accept = v && (!mem_full || wsa);
    full_n = accept || (mem_full && !wsa);
    if (accept) begin
      wd = ref_wdata(zip, ld, plan);
      q_bus.push_back({zip[40], zip[39], zip[37], zip[36:32], wd, pc});
`ifdef MEM_FWD_EN
      q_fwd.push_back({1'b0, zip[37], zip[36:32], wd});
`else
      q_fwd.push_back({zip[38], zip[37], zip[36:32], zip[31:0]});
`endif
    end
    load_last  = accept && zip[38];
    rdata_next = plan;
    @(posedge clk);
    #1;
    mem_full = full_n;
  endtask

  always @(negedge clk) begin
    if (resetn) begin
      check("ms2ws_valid", {71'h0, bus.ms2ws_valid}, {71'h0, mem_full});
      if (mem_full) begin
        if (q_bus.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL scoreboard: got beat expected none queued");
        end else begin
          check("ms2ws_bus", bus.ms2ws_bus, q_bus[0]);
          check("ms_fwd_zip", {33'h0, bus.ms_fwd_zip}, {33'h0, q_fwd[0]});
          if (bus.ws_allowin) begin
            void'(q_bus.pop_front());
            void'(q_fwd.pop_front());
          end
        end
      end else begin
        check("bubble_fwd", {70'h0, bus.ms_fwd_zip[38:37]}, 72'h0);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic        v;
    logic [40:0] zip;
    logic [31:0] pc;
    logic [4:0]  ld;
    logic [31:0] plan;
    logic [31:0] alu;
    logic        rfm;
    int          kind;

    bus.es2ms_valid         = 1'b0;
    bus.es_rf_zip           = '0;
    bus.es_pc               = '0;
    bus.es_res_from_mem_zip = '0;
    bus.data_sram_rdata     = '0;
    bus.ws_allowin          = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_valid", {71'h0, bus.ms2ws_valid}, 72'h0);
    check("reset_allowin", {71'h0, bus.ms_allowin}, 72'h1);
    check("reset_bus", bus.ms2ws_bus, 72'h0);
    check("reset_fwd", {33'h0, bus.ms_fwd_zip}, 72'h0);
    resetn = 1'b1;

    // ld.b at byte 3, ld.hu / ld.h at half 1
    drive_cycle(1, mk_zip(0, 0, 1, 1, 5'd5, 32'h0000_1003), 32'h1c00_0000, 5'b10000,
                32'h8000_0000, 1, 32'h0);
    drive_cycle(1, mk_zip(0, 0, 1, 1, 5'd6, 32'h0000_2002), 32'h1c00_0004, 5'b00001,
                32'h8001_1234, 1, 32'h0);
    drive_cycle(1, mk_zip(1, 1, 1, 1, 5'd7, 32'h0000_2002), 32'h1c00_0008, 5'b01000,
                32'h8001_1234, 1, 32'h0);
    drive_cycle(0, '0, '0, '0, '0, 1, 32'h0);

    // WB stalls three cycles; port changes under the held load
    drive_cycle(1, mk_zip(0, 0, 1, 1, 5'd8, 32'h0000_3000), 32'h1c00_0010, 5'b00100,
                32'hCAFE_F00D, 1, 32'h0);
    drive_cycle(0, '0, '0, '0, '0, 0, 32'h0);
    drive_cycle(0, '0, '0, '0, '0, 0, 32'hDEAD_BEEF);
    drive_cycle(0, '0, '0, '0, '0, 0, 32'hDEAD_BEEF);
    drive_cycle(0, '0, '0, '0, '0, 1, 32'hDEAD_BEEF);

    // add then load back-to-back
    drive_cycle(1, mk_zip(0, 0, 0, 1, 5'd9, 32'h1234_5678), 32'h1c00_0020, 5'b00000,
                32'h0, 1, 32'h0);
    drive_cycle(1, mk_zip(0, 0, 1, 1, 5'd10, 32'h0000_4001), 32'h1c00_0024, 5'b10000,
                32'h0000_A500, 1, 32'h0);
    drive_cycle(1, mk_zip(0, 0, 1, 1, 5'd11, 32'h0000_5000), 32'h1c00_0028, 5'b00010,
                32'h0000_00FF, 1, 32'h0);
    drive_cycle(0, '0, '0, '0, '0, 1, 32'h0);

    // reset while a load is held by a stalled WB
    drive_cycle(1, mk_zip(0, 1, 1, 1, 5'd12, 32'h0000_6000), 32'h1c00_0030, 5'b00100,
                32'h1234_5678, 1, 32'h0);
    drive_cycle(0, '0, '0, '0, '0, 0, 32'h0);
    drive_cycle(0, '0, '0, '0, '0, 0, 32'h5555_5555);
    resetn = 1'b0;
    #1;
    check("rst_mid_valid", {71'h0, bus.ms2ws_valid}, 72'h0);
    check("rst_mid_allowin", {71'h0, bus.ms_allowin}, 72'h1);
    check("rst_mid_bus", bus.ms2ws_bus, 72'h0);
    check("rst_mid_fwd", {33'h0, bus.ms_fwd_zip}, 72'h0);
    q_bus.delete();
    q_fwd.delete();
    mem_full  = 1'b0;
    load_last = 1'b0;
    @(posedge clk);
    #1;
    resetn = 1'b1;

    // random traffic; EXE holds an instruction until it is accepted
    v = 1'b0;
    zip = '0;
    pc = '0;
    ld = '0;
    plan = '0;
    for (int i = 0; i < 400; i++) begin
      if (!(v && mem_full && !bus.ws_allowin)) begin
        v    = ($urandom_range(0, 3) != 0);
        kind = $urandom_range(0, 5);
        alu  = $urandom;
        rfm  = 1'b1;
        ld   = '0;
        unique case (kind)
          0: ld[LD_B]  = 1'b1;
          1: ld[LD_BU] = 1'b1;
          2: begin ld[LD_H]  = 1'b1; alu[0] = 1'b0; end
          3: begin ld[LD_HU] = 1'b1; alu[0] = 1'b0; end
          4: begin ld[LD_W]  = 1'b1; alu[1:0] = 2'b00; end
          default: rfm = 1'b0;
        endcase
        zip  = mk_zip(1'($urandom), 1'($urandom), rfm, 1'($urandom), 5'($urandom), alu);
        pc   = $urandom;
        plan = $urandom;
      end
      drive_cycle(v, zip, pc, ld, plan, ($urandom_range(0, 3) != 0), $urandom);
    end

    repeat (4) drive_cycle(0, '0, '0, '0, '0, 1, 32'h0);
    check("scoreboard_drained", 72'(q_bus.size()), 72'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
